// File: rtl/axi4_timer.sv
// AXI4 slave timer: 64-bit prescaled up-counter, 64-bit compare and a level irq.
// Register access is single-beat; bursts are drained and answered with SLVERR.
module axi4_timer #(
  parameter int PRESCALE_W     = 16,
  parameter int RESET_PRESCALE = 0
) (
  input  logic        clock,
  input  logic        resetn,
  output logic        irq,
  input  logic        timer_axi4_aw_valid,
  output logic        timer_axi4_aw_ready,
  input  logic [3:0]  timer_axi4_aw_id,
  input  logic [30:0] timer_axi4_aw_addr,
  input  logic [7:0]  timer_axi4_aw_len,
  input  logic [2:0]  timer_axi4_aw_size,
  input  logic [1:0]  timer_axi4_aw_burst,
  input  logic        timer_axi4_ar_valid,
  output logic        timer_axi4_ar_ready,
  input  logic [3:0]  timer_axi4_ar_id,
  input  logic [30:0] timer_axi4_ar_addr,
  input  logic [7:0]  timer_axi4_ar_len,
  input  logic [2:0]  timer_axi4_ar_size,
  input  logic [1:0]  timer_axi4_ar_burst,
  input  logic        timer_axi4_w_valid,
  output logic        timer_axi4_w_ready,
  input  logic [63:0] timer_axi4_w_data,
  input  logic [7:0]  timer_axi4_w_strb,
  input  logic        timer_axi4_w_last,
  output logic        timer_axi4_b_valid,
  input  logic        timer_axi4_b_ready,
  output logic [3:0]  timer_axi4_b_id,
  output logic [1:0]  timer_axi4_b_resp,
  output logic        timer_axi4_r_valid,
  input  logic        timer_axi4_r_ready,
  output logic [3:0]  timer_axi4_r_id,
  output logic [63:0] timer_axi4_r_data,
  output logic [1:0]  timer_axi4_r_resp,
  output logic        timer_axi4_r_last
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t r_wstate, w_wnext;
  rstate_t r_rstate, w_rnext;

  logic [63:0]           r_count, r_compare;
  logic [2:0]            r_ctrl;
  logic                  r_pending;
  logic [PRESCALE_W-1:0] r_prescale, r_tick;

  logic [3:0]  r_wid, r_rid;
  logic [4:0]  r_woff;
  logic [7:0]  r_wlen, r_wbeat, r_rlen, r_rbeat;
  logic [1:0]  r_bresp, r_rresp;
  logic [63:0] r_rdata;

  logic        w_aw_hs, w_w_hs, w_ar_hs, w_r_hs, w_wlast_beat, w_wr, w_tick_ev, w_match;
  logic [63:0] w_wold, w_wnew, w_rdval;
  logic        w_unused;

  function automatic logic [63:0] f_merge(input logic [63:0] old, input logic [63:0] data,
                                          input logic [7:0] strb);
    logic [63:0] res;
    res = old;
    for (int i = 0; i < 8; i++)
      if (strb[i]) res[i*8 +: 8] = data[i*8 +: 8];
    return res;
  endfunction

  function automatic logic f_valid_off(input logic [4:0] off);
    return off < 5'd5;
  endfunction

  function automatic logic [63:0] f_regval(input logic [4:0] off, input logic [63:0] count,
                                           input logic [63:0] compare, input logic [2:0] ctrl,
                                           input logic pend, input logic [63:0] presc);
    case (off)
      5'd0:    return count;
      5'd1:    return compare;
      5'd2:    return {61'd0, ctrl};
      5'd3:    return {63'd0, pend};
      5'd4:    return presc;
      default: return 64'd0;
    endcase
  endfunction

  assign w_aw_hs      = timer_axi4_aw_valid && timer_axi4_aw_ready;
  assign w_w_hs       = timer_axi4_w_valid && timer_axi4_w_ready;
  assign w_ar_hs      = timer_axi4_ar_valid && timer_axi4_ar_ready;
  assign w_r_hs       = timer_axi4_r_valid && timer_axi4_r_ready;
  assign w_wlast_beat = timer_axi4_w_last || (r_wbeat == r_wlen);
  assign w_wr         = w_w_hs && (r_wlen == 8'd0) && f_valid_off(r_woff);
  assign w_tick_ev    = r_ctrl[0] && (r_tick == r_prescale);
  assign w_match      = w_tick_ev && (r_count == r_compare);
  assign w_wold       = f_regval(r_woff, r_count, r_compare, r_ctrl, r_pending, 64'(r_prescale));
  assign w_wnew       = f_merge(w_wold, timer_axi4_w_data, timer_axi4_w_strb);
  assign w_rdval      = f_regval(timer_axi4_ar_addr[7:3], r_count, r_compare, r_ctrl, r_pending,
                                 64'(r_prescale));
  assign w_unused     = ^{timer_axi4_aw_size, timer_axi4_aw_burst, timer_axi4_ar_size,
                          timer_axi4_ar_burst, timer_axi4_aw_addr[30:8], timer_axi4_aw_addr[2:0],
                          timer_axi4_ar_addr[30:8], timer_axi4_ar_addr[2:0]};

  // Write channel FSM
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_wstate <= W_IDLE;
    else         r_wstate <= w_wnext;
  end

  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE:  if (timer_axi4_aw_valid) w_wnext = W_DATA;
      W_DATA:  if (timer_axi4_w_valid && w_wlast_beat) w_wnext = W_RESP;
      W_RESP:  if (timer_axi4_b_ready) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  always_comb begin
    timer_axi4_aw_ready = resetn && (r_wstate == W_IDLE);
    timer_axi4_w_ready  = (r_wstate == W_DATA);
    timer_axi4_b_valid  = (r_wstate == W_RESP);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wid   <= '0;
      r_woff  <= '0;
      r_wlen  <= '0;
      r_wbeat <= '0;
      r_bresp <= RESP_OKAY;
    end else if (w_aw_hs) begin
      r_wid   <= timer_axi4_aw_id;
      r_woff  <= timer_axi4_aw_addr[7:3];
      r_wlen  <= timer_axi4_aw_len;
      r_wbeat <= '0;
      r_bresp <= ((timer_axi4_aw_len == 8'd0) && f_valid_off(timer_axi4_aw_addr[7:3])) ?
                 RESP_OKAY : RESP_SLVERR;
    end else if (w_w_hs) begin
      r_wbeat <= r_wbeat + 8'd1;
    end
  end

  // Read channel FSM
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_rstate <= R_IDLE;
    else         r_rstate <= w_rnext;
  end

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (timer_axi4_ar_valid) w_rnext = R_DATA;
      R_DATA:  if (timer_axi4_r_ready && timer_axi4_r_last) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  always_comb begin
    timer_axi4_ar_ready = resetn && (r_rstate == R_IDLE);
    timer_axi4_r_valid  = (r_rstate == R_DATA);
    timer_axi4_r_last   = (r_rstate == R_DATA) && (r_rbeat == r_rlen);
  end

  // Read data is captured at the ar handshake and held until the burst completes
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rid   <= '0;
      r_rlen  <= '0;
      r_rbeat <= '0;
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rid   <= timer_axi4_ar_id;
      r_rlen  <= timer_axi4_ar_len;
      r_rbeat <= '0;
      r_rdata <= (timer_axi4_ar_len == 8'd0) ? w_rdval : 64'd0;
      r_rresp <= ((timer_axi4_ar_len == 8'd0) && f_valid_off(timer_axi4_ar_addr[7:3])) ?
                 RESP_OKAY : RESP_SLVERR;
    end else if (w_r_hs) begin
      r_rbeat <= r_rbeat + 8'd1;
    end
  end

  // Timer core: software writes win over counting; a match wins over W1C
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count    <= '0;
      r_compare  <= '1;
      r_ctrl     <= '0;
      r_pending  <= 1'b0;
      r_prescale <= PRESCALE_W'(RESET_PRESCALE);
      r_tick     <= '0;
    end else begin
      if (w_wr && (r_woff == 5'd0))   r_count <= w_wnew;
      else if (w_tick_ev)             r_count <= (w_match && r_ctrl[2]) ? 64'd0 : r_count + 64'd1;
      if (w_wr && (r_woff == 5'd1))   r_compare <= w_wnew;
      if (w_wr && (r_woff == 5'd2))   r_ctrl <= w_wnew[2:0];
      if (w_match)                    r_pending <= 1'b1;
      else if (w_wr && (r_woff == 5'd3) && timer_axi4_w_strb[0] && timer_axi4_w_data[0])
                                      r_pending <= 1'b0;
      if (w_wr && (r_woff == 5'd4)) begin
        r_prescale <= w_wnew[PRESCALE_W-1:0];
        r_tick     <= '0;
      end else if (r_ctrl[0]) begin
        r_tick <= w_tick_ev ? '0 : r_tick + 1'b1;
      end
    end
  end

  assign irq               = r_pending & r_ctrl[1];
  assign timer_axi4_b_id   = r_wid;
  assign timer_axi4_b_resp = r_bresp;
  assign timer_axi4_r_id   = r_rid;
  assign timer_axi4_r_data = r_rdata;
  assign timer_axi4_r_resp = r_rresp;
endmodule

// File: tb/tb_axi4_timer.sv
// Bench for axi4_timer: bus-observing reference model feeds a scoreboard that a
// monitor drains on every b/r handshake; irq is compared against the model every cycle.
module tb_axi4_timer;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        irq;
  logic        aw_valid, aw_ready, ar_valid, ar_ready;
  logic [3:0]  aw_id, ar_id;
  logic [30:0] aw_addr, ar_addr;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst;
  logic        w_valid, w_ready, w_last;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_valid, b_ready, r_valid, r_ready, r_last;
  logic [3:0]  b_id, r_id;
  logic [1:0]  b_resp, r_resp;
  logic [63:0] r_data;

  axi4_timer #(.PRESCALE_W(16), .RESET_PRESCALE(0)) dut (
    .clock(clock), .resetn(resetn), .irq(irq),
    .timer_axi4_aw_valid(aw_valid), .timer_axi4_aw_ready(aw_ready), .timer_axi4_aw_id(aw_id),
    .timer_axi4_aw_addr(aw_addr), .timer_axi4_aw_len(aw_len), .timer_axi4_aw_size(aw_size),
    .timer_axi4_aw_burst(aw_burst),
    .timer_axi4_ar_valid(ar_valid), .timer_axi4_ar_ready(ar_ready), .timer_axi4_ar_id(ar_id),
    .timer_axi4_ar_addr(ar_addr), .timer_axi4_ar_len(ar_len), .timer_axi4_ar_size(ar_size),
    .timer_axi4_ar_burst(ar_burst),
    .timer_axi4_w_valid(w_valid), .timer_axi4_w_ready(w_ready), .timer_axi4_w_data(w_data),
    .timer_axi4_w_strb(w_strb), .timer_axi4_w_last(w_last),
    .timer_axi4_b_valid(b_valid), .timer_axi4_b_ready(b_ready), .timer_axi4_b_id(b_id),
    .timer_axi4_b_resp(b_resp),
    .timer_axi4_r_valid(r_valid), .timer_axi4_r_ready(r_ready), .timer_axi4_r_id(r_id),
    .timer_axi4_r_data(r_data), .timer_axi4_r_resp(r_resp), .timer_axi4_r_last(r_last)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } rexp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
  rexp_t exp_r[$];
  bexp_t exp_b[$];

  // Reference state: 0 COUNT, 1 COMPARE, 2 CTRL, 3 STATUS, 4 PRESCALE
  logic [63:0] m_reg [5];
  logic [63:0] n_reg [5];
  logic [63:0] m_tick, n_tick, m_mask;
  int          m_wlen, m_woff, m_wbeats;
  bit          exp_rv, exp_bv, m_wr, m_tev, m_match;
  rexp_t       mr;
  bexp_t       mb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] strb_mask(input logic [7:0] s);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{s[i]}};
    return m;
  endfunction

  // Everything sampled here is what the next rising edge will see
  always @(negedge clock) begin : model_p
    if (!resetn) begin
      m_reg[0] = '0; m_reg[1] = '1; m_reg[2] = '0; m_reg[3] = '0; m_reg[4] = '0;
      m_tick = '0; m_wlen = 0; m_woff = 0; m_wbeats = 0;
      exp_r.delete(); exp_b.delete(); exp_rv = 0; exp_bv = 0;
    end else begin
      if (exp_rv) chk("r_valid_latency", 64'(r_valid), 64'd1);
      if (exp_bv) chk("b_valid_latency", 64'(b_valid), 64'd1);
      exp_rv = 0; exp_bv = 0;
      chk("irq", 64'(irq), 64'(m_reg[3][0] & m_reg[2][1]));
      if (b_valid && b_ready) begin
        if (exp_b.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected: got id %0h resp %0h, required no response", b_id, b_resp);
        end else begin
          mb = exp_b.pop_front();
          chk("b_id", 64'(b_id), 64'(mb.id));
          chk("b_resp", 64'(b_resp), 64'(mb.resp));
        end
      end
      if (r_valid && r_ready) begin
        if (exp_r.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL r_unexpected: got data %h, required no beat", r_data);
        end else begin
          mr = exp_r.pop_front();
          chk("r_id", 64'(r_id), 64'(mr.id));
          chk("r_data", r_data, mr.data);
          chk("r_resp", 64'(r_resp), 64'(mr.resp));
          chk("r_last", 64'(r_last), 64'(mr.last));
        end
      end
      m_wr = 0;
      if (w_valid && w_ready) begin
        m_wbeats++;
        m_wr = (m_wlen == 0) && (m_woff < 5);
        if (w_last || m_wbeats == m_wlen + 1) exp_bv = 1;
      end
      if (aw_valid && aw_ready) begin
        m_wlen = int'(aw_len); m_woff = int'(aw_addr[7:3]); m_wbeats = 0;
        mb.id = aw_id;
        mb.resp = (m_wlen == 0 && m_woff < 5) ? 2'b00 : 2'b10;
        exp_b.push_back(mb);
      end
      if (ar_valid && ar_ready) begin
        for (int i = 0; i <= int'(ar_len); i++) begin
          mr.id = ar_id;
          mr.last = (i == int'(ar_len));
          if (ar_len == 0 && ar_addr[7:3] < 5) begin
            mr.data = m_reg[ar_addr[7:3]]; mr.resp = 2'b00;
          end else begin
            mr.data = '0; mr.resp = 2'b10;
          end
          exp_r.push_back(mr);
        end
        exp_rv = 1;
      end
      // Timer rules for the coming edge
      n_reg = m_reg;
      n_tick = m_tick;
      m_tev = m_reg[2][0] && (m_tick == m_reg[4]);
      m_match = m_tev && (m_reg[0] == m_reg[1]);
      if (m_reg[2][0]) n_tick = m_tev ? 64'd0 : m_tick + 64'd1;
      if (m_tev) n_reg[0] = (m_match && m_reg[2][2]) ? 64'd0 : m_reg[0] + 64'd1;
      if (m_wr) begin
        m_mask = strb_mask(w_strb);
        case (m_woff)
          0: n_reg[0] = (m_reg[0] & ~m_mask) | (w_data & m_mask);
          1: n_reg[1] = (m_reg[1] & ~m_mask) | (w_data & m_mask);
          2: n_reg[2] = ((m_reg[2] & ~m_mask) | (w_data & m_mask)) & 64'h7;
          3: if (w_strb[0] && w_data[0]) n_reg[3] = 64'd0;
          default: begin
            n_reg[4] = ((m_reg[4] & ~m_mask) | (w_data & m_mask)) & 64'hFFFF;
            n_tick = 64'd0;
          end
        endcase
      end
      if (m_match) n_reg[3] = 64'd1;
      m_reg = n_reg;
      m_tick = n_tick;
    end
  end

  initial begin
    r_ready = 1'b1; b_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      r_ready = ($urandom_range(0, 3) != 0);
      b_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ch: 0 aw, 1 w, 2 ar, 3 b handshake, 4 last r handshake
  task automatic hs(input int ch, input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      case (ch)
        0: ok = aw_ready;
        1: ok = w_ready;
        2: ok = ar_ready;
        3: ok = b_valid && b_ready;
        default: ok = r_valid && r_ready && r_last;
      endcase
      @(posedge clock); #1;
      if (ok) break;
    end
    if (!ok) chk({"timeout_", name}, 64'd0, 64'd1);
  endtask

  task automatic do_write(input logic [30:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, input int len, input logic [3:0] id);
    aw_valid = 1; aw_addr = addr; aw_len = 8'(len); aw_id = id; aw_size = 3'd3; aw_burst = 2'd1;
    hs(0, "aw");
    aw_valid = 0;
    for (int b = 0; b <= len; b++) begin
      w_valid = 1; w_strb = strb; w_last = (b == len);
      w_data = (b == 0) ? data : {$urandom, $urandom};
      hs(1, "w");
    end
    w_valid = 0; w_last = 0;
    hs(3, "b");
  endtask

  task automatic do_read(input logic [30:0] addr, input int len, input logic [3:0] id);
    ar_valid = 1; ar_addr = addr; ar_len = 8'(len); ar_id = id; ar_size = 3'd3; ar_burst = 2'd1;
    hs(2, "ar");
    ar_valid = 0;
    hs(4, "r");
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin
    aw_valid = 0; aw_addr = '0; aw_len = '0; aw_id = '0; aw_size = '0; aw_burst = '0;
    ar_valid = 0; ar_addr = '0; ar_len = '0; ar_id = '0; ar_size = '0; ar_burst = '0;
    w_valid = 0; w_data = '0; w_strb = '0; w_last = 0;
    repeat (2) @(negedge clock);
    chk("rst_aw_ready", 64'(aw_ready), 0); chk("rst_ar_ready", 64'(ar_ready), 0);
    chk("rst_w_ready", 64'(w_ready), 0);   chk("rst_b_valid", 64'(b_valid), 0);
    chk("rst_r_valid", 64'(r_valid), 0);   chk("rst_irq", 64'(irq), 0);
    chk("rst_r_last", 64'(r_last), 0);     chk("rst_r_data", r_data, 0);
    chk("rst_r_resp", 64'(r_resp), 0);     chk("rst_b_resp", 64'(b_resp), 0);
    chk("rst_r_id", 64'(r_id), 0);         chk("rst_b_id", 64'(b_id), 0);
    @(posedge clock); #1 resetn = 1;

    do_read(31'h08, 0, 4'h5);
    do_write(31'h20, 64'd3, 8'hFF, 0, 4'h1);
    do_write(31'h10, 64'd1, 8'hFF, 0, 4'h2);
    wait_cycles(40);
    do_read(31'h00, 0, 4'h3);

    do_write(31'h10, 64'd0, 8'hFF, 0, 4'h4);
    do_write(31'h00, 64'd0, 8'hFF, 0, 4'h4);
    do_write(31'h00, 64'h1111_2222_3333_4444, 8'h0F, 0, 4'h4);
    do_read(31'h00, 0, 4'h4);

    do_write(31'h20, 64'd0, 8'hFF, 0, 4'h1);
    do_write(31'h08, 64'd5, 8'hFF, 0, 4'h1);
    do_write(31'h00, 64'd0, 8'hFF, 0, 4'h1);
    do_write(31'h10, 64'd7, 8'hFF, 0, 4'h1);
    for (int i = 0; i < 20; i++) begin
      wait_cycles($urandom_range(0, 7));
      do_write(31'h18, 64'd1, 8'h01, 0, 4'(i));
      if (i % 4 == 0) do_read(31'h00, 0, 4'(i));
    end

    do_write(31'h08, 64'hDEAD_BEEF, 8'hFF, 3, 4'h6);
    do_read(31'h08, 0, 4'h7);
    do_read(31'h00, 2, 4'h8);
    do_read(31'h28, 0, 4'h9);
    do_write(31'h30, 64'h55, 8'hFF, 0, 4'hA);

    fork
      for (int i = 0; i < 30; i++)
        do_write(31'(($urandom & 32'h7FFF_FF00) | ($urandom_range(0, 5) << 3) | $urandom_range(0, 7)),
                 {$urandom, $urandom}, 8'($urandom),
                 ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0, 4'($urandom));
      for (int i = 0; i < 30; i++)
        do_read(31'(($urandom & 32'h7FFF_FF00) | ($urandom_range(0, 6) << 3) | $urandom_range(0, 7)),
                ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0, 4'($urandom));
    join

    aw_valid = 1; aw_addr = 31'h08; aw_len = 8'd2; aw_id = 4'hC;
    hs(0, "aw_abort");
    aw_valid = 0;
    w_valid = 1; w_data = 64'h1234; w_strb = 8'hFF; w_last = 0;
    hs(1, "w_abort");
    w_valid = 0;
    resetn = 0;
    @(negedge clock);
    chk("abort_b_valid", 64'(b_valid), 0); chk("abort_w_ready", 64'(w_ready), 0);
    chk("abort_aw_ready", 64'(aw_ready), 0); chk("abort_irq", 64'(irq), 0);
    wait_cycles(2);
    resetn = 1;
    @(negedge clock);
    chk("post_abort_aw_ready", 64'(aw_ready), 1); chk("post_abort_w_ready", 64'(w_ready), 0);
    chk("post_abort_b_valid", 64'(b_valid), 0);
    @(posedge clock); #1;
    do_read(31'h08, 0, 4'hD);
    do_write(31'h08, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 4'hE);
    do_read(31'h08, 0, 4'hF);

    for (int k = 0; k < 500 && (exp_b.size() + exp_r.size()) != 0; k++) @(negedge clock);
    chk("queues_drained", 64'(exp_b.size() + exp_r.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi4_timer.md
Name: axi4_timer

Overview:
- AXI4 slave timer peripheral attached to one master port of the MMIO peripheral crossbar, alongside the UART, BRAM and SPI slaves.
- Provides a 64-bit prescaled up-counter, a 64-bit compare register and a level interrupt.
- Register access is single-beat. Bursts are fully consumed and answered with SLVERR so the crossbar never stalls.

Parameters:
- PRESCALE_W, 16, width of the prescale divider register and the internal tick counter.
- RESET_PRESCALE, 0, reset value of PRESCALE; 0 means one count per clock.

Ports:
- clock  input  1  single clock for all logic.
- resetn  input  1  asynchronous active-low reset; all state is cleared when it is 0.
- irq  output  1  level interrupt = STATUS.pending & CTRL.irq_en.
- timer_axi4_aw_valid/ar_valid  input  1 each  address valid.
- timer_axi4_aw_ready/ar_ready  output  1 each  address ready.
- timer_axi4_aw_id/ar_id  input  4 each  transaction ID.
- timer_axi4_aw_addr/ar_addr  input  31 each  byte address; only bits [7:0] are decoded.
- timer_axi4_aw_len/ar_len  input  8 each  burst length minus 1.
- timer_axi4_aw_size/ar_size  input  3 each  ignored; byte enables come from wstrb.
- timer_axi4_aw_burst/ar_burst  input  2 each  ignored.
- timer_axi4_w_valid  input  1 / timer_axi4_w_ready  output  1  write data handshake.
- timer_axi4_w_data  input  64 / timer_axi4_w_strb  input  8 / timer_axi4_w_last  input  1.
- timer_axi4_b_valid  output  1 / timer_axi4_b_ready  input  1  write response handshake.
- timer_axi4_b_id  output  4 / timer_axi4_b_resp  output  2.
- timer_axi4_r_valid  output  1 / timer_axi4_r_ready  input  1  read data handshake.
- timer_axi4_r_id  output  4 / timer_axi4_r_data  output  64 / timer_axi4_r_resp  output  2 / timer_axi4_r_last  output  1.

Behaviour:
- Reset values (resetn=0, asynchronous): all AXI ready/valid outputs 0; b_resp, r_resp, r_data, IDs 0; r_last 0; irq 0.
- Reset register state: COUNT=0, COMPARE=all ones, CTRL=0, pending=0, PRESCALE=RESET_PRESCALE, tick counter=0.
- Register map (addr[7:3]):
  - 0x00 COUNT, RW.
  - 0x08 COMPARE, RW.
  - 0x10 CTRL, RW: bit0 enable, bit1 irq_en, bit2 autoreload; other bits read 0.
  - 0x18 STATUS, bit0 pending, write-1-to-clear.
  - 0x20 PRESCALE, RW, low PRESCALE_W bits.
  - Any other offset: reads return 0 with SLVERR; writes are ignored with SLVERR.
- Writes are byte-granular per w_strb. addr[2:0] is ignored.
- Write FSM:
  - W_IDLE: aw_ready=1. On aw handshake, latch id, offset and len, then go to W_DATA.
  - W_DATA: w_ready=1. Each beat handshakes. The register is updated only if latched len==0. On the beat with w_last=1 (or the beat-count reaching len+1, whichever comes first), go to W_RESP.
  - W_RESP: b_valid=1; b_resp=OKAY (2'b00) for len==0 and a valid offset, else SLVERR (2'b10). Hold until b_ready, then go to W_IDLE.
- Read FSM, independent of the write FSM:
  - R_IDLE: ar_ready=1. On handshake, latch id, offset and len; beat counter=0; go to R_DATA.
  - R_DATA: r_valid=1.
    - len==0: r_data=register value sampled in the cycle of ar handshake; r_resp=OKAY, or SLVERR for an invalid offset.
    - len>0: r_data=0, r_resp=SLVERR for all len+1 beats.
    - r_last=1 on beat len. Outputs are held stable while r_ready=0. After the last handshake, go to R_IDLE.
- Latency: aw/ar is accepted in the cycle valid is seen in IDLE. The first r_valid appears 1 cycle after the ar handshake. b_valid appears 1 cycle after the last w handshake.
- Counter:
  - When enable=1, the tick counter increments each clock. When tick==PRESCALE, tick wraps to 0 and COUNT+=1, wrapping 2^64-1 -> 0.
  - enable=0 freezes both COUNT and tick.
  - A write to PRESCALE clears tick.
- Match: when COUNT==COMPARE and enable=1 on a tick cycle, pending is set. With autoreload=1, COUNT loads 0 instead of incrementing on that tick.
- Simultaneous events:
  - A software write to COUNT beats an increment or autoreload in the same cycle.
  - A match set beats a W1C clear in the same cycle.
  - A write to COMPARE takes effect for the next cycle's comparison.
- Reset asserted mid-burst: both FSMs return to IDLE immediately. No response is issued for the aborted transaction.

Test Plan:
- Reset -> all ready/valid outputs 0 and irq 0. Read 0x08 returns 64'hFFFF_FFFF_FFFF_FFFF, OKAY, r_last=1, r_id=the ar_id.
- Write PRESCALE=3, CTRL=0x1, then wait 40 clocks -> COUNT reads 10 (±1 depending on sample cycle; the bench computes exact cycles).
- COMPARE=5, CTRL=0x7, PRESCALE=0 -> irq rises exactly when COUNT==5, and COUNT restarts at 0. Writing 1 to STATUS drops irq the next cycle unless a match coincides, in which case irq stays 1.
- Write 0x00 with w_strb=8'h0F, data=64'h1111_2222_3333_4444 over the existing COUNT=0 with enable=0 -> COUNT reads 64'h0000_0000_3333_4444.
- aw_len=3 with 4 beats to COMPARE -> COMPARE unchanged, one b with SLVERR. ar_len=2 -> 3 beats of data 0 with SLVERR, r_last only on the 3rd beat, with r_ready toggled randomly.
- Read 0x28 -> data 0 with SLVERR. Concurrent read and write streams proceed independently without deadlock. Asserting resetn=0 during W_DATA -> no b response, and the FSM is back in IDLE when resetn returns to 1.
